// File: rtl/ysyx_24110006_mem_arbiter.sv
// Two-master AXI4 arbiter: LSU (m1) has fixed priority over fetch (m0); one whole transaction at a time.
// Grant is registered out of IDLE; while granted, the owner's channels are wired straight through.
module ysyx_24110006_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                i_clock,
   input  logic                i_reset,
   // fetch read port
   input  logic [ADDR_W-1:0]   i_m0_araddr,
   input  logic                i_m0_arvalid,
   input  logic [ID_W-1:0]     i_m0_arid,
   input  logic [7:0]          i_m0_arlen,
   input  logic [2:0]          i_m0_arsize,
   input  logic [1:0]          i_m0_arburst,
   output logic                o_m0_arready,
   output logic [DATA_W-1:0]   o_m0_rdata,
   output logic                o_m0_rvalid,
   output logic [1:0]          o_m0_rresp,
   output logic                o_m0_rlast,
   output logic [ID_W-1:0]     o_m0_rid,
   input  logic                i_m0_rready,
   // LSU read port
   input  logic [ADDR_W-1:0]   i_m1_araddr,
   input  logic                i_m1_arvalid,
   input  logic [ID_W-1:0]     i_m1_arid,
   input  logic [7:0]          i_m1_arlen,
   input  logic [2:0]          i_m1_arsize,
   input  logic [1:0]          i_m1_arburst,
   output logic                o_m1_arready,
   output logic [DATA_W-1:0]   o_m1_rdata,
   output logic                o_m1_rvalid,
   output logic [1:0]          o_m1_rresp,
   output logic                o_m1_rlast,
   output logic [ID_W-1:0]     o_m1_rid,
   input  logic                i_m1_rready,
   // LSU write port
   input  logic [ADDR_W-1:0]   i_m1_awaddr,
   input  logic                i_m1_awvalid,
   input  logic [ID_W-1:0]     i_m1_awid,
   input  logic [7:0]          i_m1_awlen,
   input  logic [2:0]          i_m1_awsize,
   input  logic [1:0]          i_m1_awburst,
   output logic                o_m1_awready,
   input  logic [DATA_W-1:0]   i_m1_wdata,
   input  logic [DATA_W/8-1:0] i_m1_wstrb,
   input  logic                i_m1_wvalid,
   input  logic                i_m1_wlast,
   output logic                o_m1_wready,
   output logic                o_m1_bvalid,
   output logic [1:0]          o_m1_bresp,
   output logic [ID_W-1:0]     o_m1_bid,
   input  logic                i_m1_bready,
   // downstream master port
   output logic [ADDR_W-1:0]   o_axi_araddr,
   output logic                o_axi_arvalid,
   output logic [ID_W-1:0]     o_axi_arid,
   output logic [7:0]          o_axi_arlen,
   output logic [2:0]          o_axi_arsize,
   output logic [1:0]          o_axi_arburst,
   input  logic                i_axi_arready,
   input  logic [DATA_W-1:0]   i_axi_rdata,
   input  logic                i_axi_rvalid,
   input  logic [1:0]          i_axi_rresp,
   input  logic                i_axi_rlast,
   input  logic [ID_W-1:0]     i_axi_rid,
   output logic                o_axi_rready,
   output logic [ADDR_W-1:0]   o_axi_awaddr,
   output logic                o_axi_awvalid,
   output logic [ID_W-1:0]     o_axi_awid,
   output logic [7:0]          o_axi_awlen,
   output logic [2:0]          o_axi_awsize,
   output logic [1:0]          o_axi_awburst,
   input  logic                i_axi_awready,
   output logic [DATA_W-1:0]   o_axi_wdata,
   output logic [DATA_W/8-1:0] o_axi_wstrb,
   output logic                o_axi_wvalid,
   output logic                o_axi_wlast,
   input  logic                i_axi_wready,
   input  logic                i_axi_bvalid,
   input  logic [1:0]          i_axi_bresp,
   input  logic [ID_W-1:0]     i_axi_bid,
   output logic                o_axi_bready
);

   typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

   state_t state, state_nxt;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   // Release only on the accepted last beat / accepted write response, never mid-burst.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_m1_awvalid)      state_nxt = WR1;
            else if (i_m1_arvalid) state_nxt = RD1;
            else if (i_m0_arvalid) state_nxt = RD0;
         end
         RD0:     if (i_axi_rvalid && i_m0_rready && i_axi_rlast) state_nxt = IDLE;
         RD1:     if (i_axi_rvalid && i_m1_rready && i_axi_rlast) state_nxt = IDLE;
         WR1:     if (i_axi_bvalid && i_m1_bready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_axi_araddr = '0; o_axi_arvalid = 1'b0; o_axi_arid = '0;
      o_axi_arlen = '0; o_axi_arsize = '0; o_axi_arburst = '0; o_axi_rready = 1'b0;
      o_axi_awaddr = '0; o_axi_awvalid = 1'b0; o_axi_awid = '0;
      o_axi_awlen = '0; o_axi_awsize = '0; o_axi_awburst = '0;
      o_axi_wdata = '0; o_axi_wstrb = '0; o_axi_wvalid = 1'b0; o_axi_wlast = 1'b0;
      o_axi_bready = 1'b0;
      o_m0_arready = 1'b0; o_m0_rdata = '0; o_m0_rvalid = 1'b0;
      o_m0_rresp = '0; o_m0_rlast = 1'b0; o_m0_rid = '0;
      o_m1_arready = 1'b0; o_m1_rdata = '0; o_m1_rvalid = 1'b0;
      o_m1_rresp = '0; o_m1_rlast = 1'b0; o_m1_rid = '0;
      o_m1_awready = 1'b0; o_m1_wready = 1'b0;
      o_m1_bvalid = 1'b0; o_m1_bresp = '0; o_m1_bid = '0;
      case (state)
         RD0: begin
            o_axi_araddr  = i_m0_araddr;  o_axi_arvalid = i_m0_arvalid;
            o_axi_arid    = i_m0_arid;    o_axi_arlen   = i_m0_arlen;
            o_axi_arsize  = i_m0_arsize;  o_axi_arburst = i_m0_arburst;
            o_axi_rready  = i_m0_rready;
            o_m0_arready  = i_axi_arready;
            o_m0_rdata    = i_axi_rdata;  o_m0_rvalid   = i_axi_rvalid;
            o_m0_rresp    = i_axi_rresp;  o_m0_rlast    = i_axi_rlast;
            o_m0_rid      = i_axi_rid;
         end
         RD1: begin
            o_axi_araddr  = i_m1_araddr;  o_axi_arvalid = i_m1_arvalid;
            o_axi_arid    = i_m1_arid;    o_axi_arlen   = i_m1_arlen;
            o_axi_arsize  = i_m1_arsize;  o_axi_arburst = i_m1_arburst;
            o_axi_rready  = i_m1_rready;
            o_m1_arready  = i_axi_arready;
            o_m1_rdata    = i_axi_rdata;  o_m1_rvalid   = i_axi_rvalid;
            o_m1_rresp    = i_axi_rresp;  o_m1_rlast    = i_axi_rlast;
            o_m1_rid      = i_axi_rid;
         end
         // AW and W are independent here; the slave may take them in either order.
         WR1: begin
            o_axi_awaddr  = i_m1_awaddr;  o_axi_awvalid = i_m1_awvalid;
            o_axi_awid    = i_m1_awid;    o_axi_awlen   = i_m1_awlen;
            o_axi_awsize  = i_m1_awsize;  o_axi_awburst = i_m1_awburst;
            o_axi_wdata   = i_m1_wdata;   o_axi_wstrb   = i_m1_wstrb;
            o_axi_wvalid  = i_m1_wvalid;  o_axi_wlast   = i_m1_wlast;
            o_axi_bready  = i_m1_bready;
            o_m1_awready  = i_axi_awready;
            o_m1_wready   = i_axi_wready;
            o_m1_bvalid   = i_axi_bvalid; o_m1_bresp    = i_axi_bresp;
            o_m1_bid      = i_axi_bid;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
// Bench: randomized fetch/LSU masters and a downstream slave, checked against an owner-level model
// of the arbitration rules plus end-to-end beat, id and burst-length scoreboards.
module tb_ysyx_24110006_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] m0_araddr, m0_rdata, m1_araddr, m1_rdata, m1_awaddr, m1_wdata;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
   logic [3:0]  m0_arid, m0_rid, m1_arid, m1_rid, m1_awid, m1_bid, m1_wstrb;
   logic [7:0]  m0_arlen, m1_arlen, m1_awlen;
   logic [2:0]  m0_arsize, m1_arsize, m1_awsize;
   logic [1:0]  m0_arburst, m0_rresp, m1_arburst, m1_rresp, m1_awburst, m1_bresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
   logic        m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
   logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
   logic        axi_arvalid, axi_arready, axi_rvalid, axi_rlast, axi_rready;
   logic [3:0]  axi_arid, axi_rid, axi_awid, axi_bid, axi_wstrb;
   logic [7:0]  axi_arlen, axi_awlen;
   logic [2:0]  axi_arsize, axi_awsize;
   logic [1:0]  axi_arburst, axi_rresp, axi_awburst, axi_bresp;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wlast, axi_wready;
   logic        axi_bvalid, axi_bready;

   ysyx_24110006_mem_arbiter dut (
      .i_clock(clk), .i_reset(rst),
      .i_m0_araddr(m0_araddr), .i_m0_arvalid(m0_arvalid), .i_m0_arid(m0_arid),
      .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
      .o_m0_arready(m0_arready), .o_m0_rdata(m0_rdata), .o_m0_rvalid(m0_rvalid),
      .o_m0_rresp(m0_rresp), .o_m0_rlast(m0_rlast), .o_m0_rid(m0_rid), .i_m0_rready(m0_rready),
      .i_m1_araddr(m1_araddr), .i_m1_arvalid(m1_arvalid), .i_m1_arid(m1_arid),
      .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
      .o_m1_arready(m1_arready), .o_m1_rdata(m1_rdata), .o_m1_rvalid(m1_rvalid),
      .o_m1_rresp(m1_rresp), .o_m1_rlast(m1_rlast), .o_m1_rid(m1_rid), .i_m1_rready(m1_rready),
      .i_m1_awaddr(m1_awaddr), .i_m1_awvalid(m1_awvalid), .i_m1_awid(m1_awid),
      .i_m1_awlen(m1_awlen), .i_m1_awsize(m1_awsize), .i_m1_awburst(m1_awburst),
      .o_m1_awready(m1_awready), .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
      .i_m1_wvalid(m1_wvalid), .i_m1_wlast(m1_wlast), .o_m1_wready(m1_wready),
      .o_m1_bvalid(m1_bvalid), .o_m1_bresp(m1_bresp), .o_m1_bid(m1_bid), .i_m1_bready(m1_bready),
      .o_axi_araddr(axi_araddr), .o_axi_arvalid(axi_arvalid), .o_axi_arid(axi_arid),
      .o_axi_arlen(axi_arlen), .o_axi_arsize(axi_arsize), .o_axi_arburst(axi_arburst),
      .i_axi_arready(axi_arready), .i_axi_rdata(axi_rdata), .i_axi_rvalid(axi_rvalid),
      .i_axi_rresp(axi_rresp), .i_axi_rlast(axi_rlast), .i_axi_rid(axi_rid), .o_axi_rready(axi_rready),
      .o_axi_awaddr(axi_awaddr), .o_axi_awvalid(axi_awvalid), .o_axi_awid(axi_awid),
      .o_axi_awlen(axi_awlen), .o_axi_awsize(axi_awsize), .o_axi_awburst(axi_awburst),
      .i_axi_awready(axi_awready), .o_axi_wdata(axi_wdata), .o_axi_wstrb(axi_wstrb),
      .o_axi_wvalid(axi_wvalid), .o_axi_wlast(axi_wlast), .i_axi_wready(axi_wready),
      .i_axi_bvalid(axi_bvalid), .i_axi_bresp(axi_bresp), .i_axi_bid(axi_bid), .o_axi_bready(axi_bready)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [31:0] data;
      logic [3:0]  strb;
   } req_t;

   req_t        m0_q[$], m1_q[$];
   logic [31:0] beat_q[$];
   int  n_vec = 0, n_err = 0;
   int  mo = 0;  // model owner: 0 none, 1 fetch read, 2 LSU read, 3 LSU write
   bit  rnd = 0, auto_gen = 0, want_rst = 0;
   bit  m0_busy, m1_busy, m1_wr;
   int  m0_beats, m1_beats, m1_wleft, m0_iss, m0_done, m1_iss, m1_done;
   int  s_rd_left;
   bit  s_r_vld, s_rlast, s_aw_got, s_w_done, s_b_vld;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp, s_bresp;
   logic [3:0]  s_rid, s_bid;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic req_t rand_req();
      req_t r;
      r.wr   = 1'($urandom_range(1));
      r.addr = $urandom & 32'hFFFF_FFFC;
      r.len  = 8'($urandom_range(3));
      r.data = $urandom;
      r.strb = 4'($urandom_range(15));
      return r;
   endfunction

   task automatic clear_env();
      if (m0_busy) m0_iss--;
      if (m1_busy) m1_iss--;
      m0_busy = 0; m1_busy = 0; m0_beats = 0; m1_beats = 0; m1_wleft = 0;
      m0_arvalid = 0; m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0; m1_wlast = 0;
      s_rd_left = 0; s_r_vld = 0; s_aw_got = 0; s_w_done = 0; s_b_vld = 0;
      axi_rvalid = 0; axi_bvalid = 0;
      beat_q.delete();
      mo = 0;
   endtask

   task automatic drive();
      req_t r;
      rst = 0;
      if (auto_gen && !m0_busy && m0_q.size() == 0 && $urandom_range(3) == 0) m0_q.push_back(rand_req());
      if (auto_gen && !m1_busy && m1_q.size() == 0 && $urandom_range(3) == 0) m1_q.push_back(rand_req());
      if (!m0_busy && m0_q.size() > 0) begin
         r = m0_q.pop_front();
         m0_busy = 1; m0_iss++;
         m0_arvalid = 1; m0_araddr = r.addr; m0_arlen = r.len;
         m0_arid = 4'($urandom); m0_arsize = 3'd2; m0_arburst = 2'd1;
      end
      if (!m1_busy && m1_q.size() > 0) begin
         r = m1_q.pop_front();
         m1_busy = 1; m1_iss++; m1_wr = r.wr;
         if (r.wr) begin
            m1_awvalid = 1; m1_awaddr = r.addr; m1_awlen = r.len;
            m1_awid = 4'($urandom); m1_awsize = 3'd2; m1_awburst = 2'd1;
            m1_wvalid = 1; m1_wdata = r.data; m1_wstrb = r.strb;
            m1_wlast = (r.len == 0); m1_wleft = int'(r.len) + 1;
         end else begin
            m1_arvalid = 1; m1_araddr = r.addr; m1_arlen = r.len;
            m1_arid = 4'($urandom); m1_arsize = 3'd2; m1_arburst = 2'd1;
         end
      end
      m0_rready = !rnd || ($urandom_range(2) != 0);
      m1_rready = !rnd || ($urandom_range(2) != 0);
      m1_bready = !rnd || ($urandom_range(2) != 0);
      axi_arready = (s_rd_left == 0) && (!rnd || $urandom_range(1) == 1);
      axi_awready = !s_aw_got && (!rnd || $urandom_range(1) == 1);
      axi_wready  = !s_w_done && (!rnd || $urandom_range(1) == 1);
      if (!s_r_vld && s_rd_left > 0 && (!rnd || $urandom_range(1) == 1)) begin
         s_r_vld = 1; s_rlast = (s_rd_left == 1);
         s_rdata = rnd ? $urandom : 32'hDEAD_BEEF;
         s_rresp = rnd ? 2'($urandom) : 2'b00;
         beat_q.push_back(s_rdata);
      end
      if (!s_b_vld && s_aw_got && s_w_done && (!rnd || $urandom_range(1) == 1)) begin
         s_b_vld = 1; s_bresp = rnd ? 2'($urandom) : 2'b00;
      end
      // Stray responses while nothing is granted must be ignored by the arbiter.
      if (s_r_vld) begin
         axi_rvalid = 1; axi_rdata = s_rdata; axi_rlast = s_rlast; axi_rresp = s_rresp; axi_rid = s_rid;
      end else begin
         axi_rvalid = (mo == 0) && rnd && ($urandom_range(3) == 0);
         axi_rdata = $urandom; axi_rlast = 1; axi_rresp = 2'($urandom); axi_rid = 4'($urandom);
      end
      if (s_b_vld) begin
         axi_bvalid = 1; axi_bresp = s_bresp; axi_bid = s_bid;
      end else begin
         axi_bvalid = (mo == 0) && rnd && ($urandom_range(3) == 0);
         axi_bresp = 2'($urandom); axi_bid = 4'($urandom);
      end
   endtask

   task automatic check_outputs();
      logic [63:0] e_ar, e_aw, e_w, e_rb, e_m0, e_m1r, e_m1w;
      e_ar = 0; e_aw = 0; e_w = 0; e_rb = 0; e_m0 = 0; e_m1r = 0; e_m1w = 0;
      if (mo == 1) begin
         e_ar = 64'({m0_araddr, m0_arvalid, m0_arid, m0_arlen, m0_arsize, m0_arburst});
         e_rb = 64'({m0_rready, 1'b0});
         e_m0 = 64'({axi_arready, axi_rdata, axi_rvalid, axi_rresp, axi_rlast, axi_rid});
      end else if (mo == 2) begin
         e_ar  = 64'({m1_araddr, m1_arvalid, m1_arid, m1_arlen, m1_arsize, m1_arburst});
         e_rb  = 64'({m1_rready, 1'b0});
         e_m1r = 64'({axi_arready, axi_rdata, axi_rvalid, axi_rresp, axi_rlast, axi_rid});
      end else if (mo == 3) begin
         e_aw  = 64'({m1_awaddr, m1_awvalid, m1_awid, m1_awlen, m1_awsize, m1_awburst});
         e_w   = 64'({m1_wdata, m1_wstrb, m1_wvalid, m1_wlast});
         e_rb  = 64'({1'b0, m1_bready});
         e_m1w = 64'({axi_awready, axi_wready, axi_bvalid, axi_bresp, axi_bid});
      end
      chk("axi_ar", 64'({axi_araddr, axi_arvalid, axi_arid, axi_arlen, axi_arsize, axi_arburst}), e_ar);
      chk("axi_aw", 64'({axi_awaddr, axi_awvalid, axi_awid, axi_awlen, axi_awsize, axi_awburst}), e_aw);
      chk("axi_w", 64'({axi_wdata, axi_wstrb, axi_wvalid, axi_wlast}), e_w);
      chk("axi_rdy", 64'({axi_rready, axi_bready}), e_rb);
      chk("m0_port", 64'({m0_arready, m0_rdata, m0_rvalid, m0_rresp, m0_rlast, m0_rid}), e_m0);
      chk("m1_rport", 64'({m1_arready, m1_rdata, m1_rvalid, m1_rresp, m1_rlast, m1_rid}), e_m1r);
      chk("m1_wport", 64'({m1_awready, m1_wready, m1_bvalid, m1_bresp, m1_bid}), e_m1w);
   endtask

   task automatic update();
      bit h_m0ar, h_m0r, h_m1ar, h_m1r, h_m1aw, h_m1w, h_m1b, h_sar, h_sr, h_saw, h_sw, h_sb;
      logic [31:0] d0, d1;
      logic [3:0]  id0, id1, bid, sarid, sawid;
      logic        l0, l1, swl;
      logic [7:0]  sarlen;
      int mo_n;
      h_m0ar = m0_arvalid && m0_arready;   h_m0r = m0_rvalid && m0_rready;
      h_m1ar = m1_arvalid && m1_arready;   h_m1r = m1_rvalid && m1_rready;
      h_m1aw = m1_awvalid && m1_awready;   h_m1w = m1_wvalid && m1_wready;
      h_m1b  = m1_bvalid && m1_bready;
      h_sar = axi_arvalid && axi_arready;  h_sr = axi_rvalid && axi_rready && s_r_vld;
      h_saw = axi_awvalid && axi_awready;  h_sw = axi_wvalid && axi_wready;
      h_sb  = axi_bvalid && axi_bready && s_b_vld;
      d0 = m0_rdata; l0 = m0_rlast; id0 = m0_rid; d1 = m1_rdata; l1 = m1_rlast; id1 = m1_rid;
      bid = m1_bid; sarid = axi_arid; sarlen = axi_arlen; sawid = axi_awid; swl = axi_wlast;
      case (mo)
         0:       mo_n = m1_awvalid ? 3 : m1_arvalid ? 2 : m0_arvalid ? 1 : 0;
         1:       mo_n = (axi_rvalid && m0_rready && axi_rlast) ? 0 : 1;
         2:       mo_n = (axi_rvalid && m1_rready && axi_rlast) ? 0 : 2;
         default: mo_n = (axi_bvalid && m1_bready) ? 0 : 3;
      endcase
      if (h_m0ar) m0_arvalid = 0;
      if (h_m0r) begin
         m0_beats++;
         chk("m0_rdata", 64'(d0), (beat_q.size() > 0) ? 64'(beat_q.pop_front()) : 64'hBAD);
         chk("m0_rid", 64'(id0), 64'(m0_arid));
         if (!rnd) chk("fetch_dat", 64'(d0), 64'hDEAD_BEEF);
         if (l0) begin
            chk("m0_burst", 64'(m0_beats), 64'(m0_arlen) + 1);
            m0_busy = 0; m0_done++; m0_beats = 0;
         end
      end
      if (h_m1ar) m1_arvalid = 0;
      if (h_m1r) begin
         m1_beats++;
         chk("m1_rdata", 64'(d1), (beat_q.size() > 0) ? 64'(beat_q.pop_front()) : 64'hBAD);
         chk("m1_rid", 64'(id1), 64'(m1_arid));
         if (l1) begin
            chk("m1_burst", 64'(m1_beats), 64'(m1_arlen) + 1);
            m1_busy = 0; m1_done++; m1_beats = 0;
         end
      end
      if (h_m1aw) m1_awvalid = 0;
      if (h_m1w) begin
         m1_wleft--;
         if (m1_wleft == 0) begin
            m1_wvalid = 0; m1_wlast = 0;
         end else begin
            m1_wdata = $urandom; m1_wstrb = 4'($urandom); m1_wlast = (m1_wleft == 1);
         end
      end
      if (h_m1b) begin
         chk("m1_bid", 64'(bid), 64'(m1_awid));
         m1_busy = 0; m1_done++;
      end
      if (h_sar) begin s_rd_left = int'(sarlen) + 1; s_rid = sarid; end
      if (h_sr)  begin s_r_vld = 0; s_rd_left--; end
      if (h_saw) begin s_aw_got = 1; s_bid = sawid; end
      if (h_sw && swl) s_w_done = 1;
      if (h_sb)  begin s_aw_got = 0; s_w_done = 0; s_b_vld = 0; end
      mo = mo_n;
   endtask

   task automatic step();
      @(posedge clk); #1;
      drive();
      #1;
      if (want_rst && mo == 2 && s_rd_left > 0) begin
         rst = 1; #1;
         mo = 0;
         check_outputs();
         clear_env();
         want_rst = 0;
      end else begin
         check_outputs();
         update();
      end
   endtask

   task automatic run_idle(input int max_cyc);
      int n;
      n = 0;
      while ((m0_busy || m1_busy || m0_q.size() > 0 || m1_q.size() > 0 || mo != 0) && n < max_cyc) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(n < max_cyc), 64'd1);
   endtask

   initial begin
      req_t r;
      m0_iss = 0; m0_done = 0; m1_iss = 0; m1_done = 0;
      m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0; m0_rready = 0;
      m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0; m1_rready = 0;
      m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_awsize = 0; m1_awburst = 0;
      m1_wdata = 0; m1_wstrb = 0; m1_bready = 0;
      axi_arready = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 0; axi_rid = 0;
      axi_awready = 0; axi_wready = 0; axi_bresp = 0; axi_bid = 0;
      clear_env();
      #1 rst = 1;
      repeat (2) @(posedge clk);
      #2 check_outputs();

      // single fetch, then simultaneous fetch/LSU reads (LSU wins), then a partial-strobe store
      r = '{wr: 0, addr: 32'h8000_0000, len: 8'd0, data: 0, strb: 0};
      m0_q.push_back(r); run_idle(50);
      m0_q.push_back(r);
      m1_q.push_back('{wr: 0, addr: 32'hA000_0000, len: 8'd0, data: 0, strb: 0});
      run_idle(50);
      m1_q.push_back('{wr: 1, addr: 32'h8000_0010, len: 8'd0, data: 32'h1234_5678, strb: 4'b1100});
      run_idle(50);
      // four-beat fetch burst with an LSU read arriving mid-burst
      m0_q.push_back('{wr: 0, addr: 32'h8000_0000, len: 8'd3, data: 0, strb: 0});
      repeat (3) step();
      m1_q.push_back('{wr: 0, addr: 32'hA000_0000, len: 8'd1, data: 0, strb: 0});
      run_idle(50);

      rnd = 1; auto_gen = 1;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) want_rst = 1;
         step();
      end
      auto_gen = 0;
      run_idle(500);
      chk("rst_mid_read_seen", 64'(want_rst), 64'd0);
      chk("m0_txns", 64'(m0_done), 64'(m0_iss));
      chk("m1_txns", 64'(m1_done), 64'(m1_iss));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
